mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 100 ++++++++++
 tb/tb_mult_div_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per RUN cycle on magnitudes; signs are applied in FIN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] moveData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [W2-1:0]    p;
    logic             sa, sb, dz;
    logic [WIDTH-1:0] ma, mb, quo, rem, res_hi, res_lo;
    logic [WIDTH:0]   mul_sum, div_t, div_d;
    logic [W2-1:0]    p_step, prod;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;

    always_comb
        state_next = (state == IDLE) ? (start ? RUN : IDLE) :
                     (state == RUN)  ? (&cnt ? FIN : RUN) : IDLE;

    // p holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        sa      = op_q[0] & a_q[WIDTH-1];
        sb      = op_q[0] & b_q[WIDTH-1];
        ma      = sa ? -a_q : a_q;
        mb      = sb ? -b_q : b_q;
        dz      = b_q == '0;
        mul_sum = {1'b0, p[W2-1:WIDTH]} + (p[0] ? {1'b0, ma} : '0);
        div_t   = {p[W2-1:WIDTH], p[WIDTH-1]};
        div_d   = div_t - {1'b0, mb};
        p_step  = op_q[1] ? (div_d[WIDTH] ? {div_t[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                          : {div_d[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                          : {mul_sum, p[WIDTH-1:1]};
        prod    = (sa ^ sb) ? -p : p;
        quo     = (sa ^ sb) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem     = sa ? -p[W2-1:WIDTH] : p[W2-1:WIDTH];
        res_hi  = op_q[1] ? (dz ? a_q : rem) : prod[W2-1:WIDTH];
        res_lo  = op_q[1] ? (dz ? '1 : quo) : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            p    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            busy <= state_next != IDLE;
            done <= state == FIN;
            if (state == IDLE) begin
                if (hiWrite) hi <= moveData;
                if (loWrite) lo <= moveData;
                if (start) begin
                    op_q <= op;
                    a_q  <= srcA;
                    b_q  <= srcB;
                    cnt  <= '0;
                    p    <= {{WIDTH{1'b0}}, op[1] ? mag(srcA, op[0]) : mag(srcB, op[0])};
                end
            end else if (state == RUN) begin
                p   <= p_step;
                cnt <= cnt + 1'b1;
            end else begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srcA = '0, srcB = '0, moveData = '0;
    logic        hiWrite = 1'b0, loWrite = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          checks = 0;
    int          errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .hiWrite(hiWrite), .loWrite(loWrite), .moveData(moveData),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Starts an op, scrambles operands after acceptance, and runs until done (bounded).
    // cyc = cycle in which done is seen (accepting edge = edge 0), nbusy = cycles with busy=1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int nbusy);
        @(negedge clk);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; srcA = 32'h5A5A_1234; srcB = 32'h0F0F_0F0F; op = ~o;
        cyc = 1; nbusy = 0;
        while (!done && cyc < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_move;
        @(negedge clk);
        moveData = 32'hCAFE_0001; hiWrite = 1'b1;
        @(negedge clk);
        hiWrite = 1'b0;
        checks += 2;
        if (hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi_hi: got %h want cafe0001", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo: got %h want 0", lo); end
        moveData = 32'h0BAD_F00D; hiWrite = 1'b1; loWrite = 1'b1;
        @(negedge clk);
        hiWrite = 1'b0; loWrite = 1'b0;
        checks += 2;
        if (hi !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtboth_hi: got %h want 0badf00d", hi); end
        if (lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtboth_lo: got %h want 0badf00d", lo); end
    endtask

    task automatic test_multu;
        int cyc, nb;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, nb);
        checks += 6;
        if (cyc !== 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", cyc); end
        if (nb !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", nb); end
        if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
        if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
        if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult;
        int cyc, nb;
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, cyc, nb);
        checks += 3;
        if (cyc !== 34) begin errors++; $display("FAIL mult_latency: got %0d want 34", cyc); end
        if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        run_op(2'b01, 32'h0001_0000, 32'hFFFF_0000, cyc, nb);
        checks += 2;
        if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult2_hi: got %h want ffffffff", hi); end
        if (lo !== 32'h0000_0000) begin errors++; $display("FAIL mult2_lo: got %h want 00000000", lo); end
    endtask

    task automatic test_div;
        int cyc, nb;
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, cyc, nb);
        checks += 3;
        if (cyc !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", cyc); end
        if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc, nb);
        checks += 2;
        if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
        run_op(2'b11, 32'h0000_0011, 32'hFFFF_FFFB, cyc, nb);
        checks += 2;
        if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdivisor_lo: got %h want fffffffd", lo); end
        if (hi !== 32'h0000_0002) begin errors++; $display("FAIL div_negdivisor_hi: got %h want 00000002", hi); end
        run_op(2'b10, 32'd100, 32'd7, cyc, nb);
        checks += 2;
        if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    endtask

    task automatic test_div_zero;
        int cyc, nb;
        run_op(2'b10, 32'h0000_0064, 32'h0, cyc, nb);
        checks += 4;
        if (nb !== 33) begin errors++; $display("FAIL divu0_busy_cycles: got %0d want 33", nb); end
        if (cyc !== 34) begin errors++; $display("FAIL divu0_latency: got %0d want 34", cyc); end
        if (hi !== 32'h0000_0064) begin errors++; $display("FAIL divu0_hi: got %h want 00000064", hi); end
        if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0, cyc, nb);
        checks += 2;
        if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div0_hi: got %h want fffffff9", hi); end
        if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
    endtask

    task automatic test_ignore_while_busy;
        int cyc, ndone;
        @(negedge clk);
        moveData = 32'h0000_0055; hiWrite = 1'b1; loWrite = 1'b1;
        @(negedge clk);
        hiWrite = 1'b0; loWrite = 1'b0;
        op = 2'b00; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; ndone = 0;
        while (cyc < 40) begin
            if (cyc == 5) begin
                start = 1'b1; op = 2'b11; srcA = 32'h7; srcB = 32'h0; hiWrite = 1'b1; moveData = 32'hDEAD_BEEF;
            end
            if (cyc == 6) begin
                start = 1'b0; hiWrite = 1'b0;
                checks += 2;
                if (hi !== 32'h55) begin errors++; $display("FAIL busy_mthi_ignored: got %h want 00000055", hi); end
                if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_run: got %b want 1", busy); end
            end
            if (cyc == 20) begin
                checks++;
                if (lo !== 32'h55) begin errors++; $display("FAIL run_lo_hold: got %h want 00000055", lo); end
            end
            if (done) ndone++;
            @(negedge clk);
            cyc++;
        end
        checks += 3;
        if (ndone !== 1) begin errors++; $display("FAIL busy_single_done: got %0d want 1", ndone); end
        if (hi !== 32'h0) begin errors++; $display("FAIL busy_result_hi: got %h want 0", hi); end
        if (lo !== 32'h0000_000C) begin errors++; $display("FAIL busy_result_lo: got %h want 0000000c", lo); end
    endtask

    task automatic test_start_with_move;
        int cyc;
        @(negedge clk);
        op = 2'b00; srcA = 32'd6; srcB = 32'd7; start = 1'b1; loWrite = 1'b1; moveData = 32'h0000_ABCD;
        @(negedge clk);
        start = 1'b0; loWrite = 1'b0;
        checks += 2;
        if (lo !== 32'h0000_ABCD) begin errors++; $display("FAIL startmove_lo: got %h want 0000abcd", lo); end
        if (busy !== 1'b1) begin errors++; $display("FAIL startmove_busy: got %b want 1", busy); end
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks += 2;
        if (cyc !== 34) begin errors++; $display("FAIL startmove_latency: got %0d want 34", cyc); end
        if (lo !== 32'd42) begin errors++; $display("FAIL startmove_result: got %h want 0000002a", lo); end
    endtask

    task automatic test_reset_abort;
        int ndone;
        @(negedge clk);
        op = 2'b10; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (hi !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h want 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        checks += 2;
        if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
        if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo_after: got %h want 0", lo); end
        moveData = 32'h0000_1234; loWrite = 1'b1;
        @(negedge clk);
        loWrite = 1'b0;
        checks += 2;
        if (lo !== 32'h0000_1234) begin errors++; $display("FAIL abort_mtlo: got %h want 00001234", lo); end
        if (hi !== 32'h0) begin errors++; $display("FAIL abort_mtlo_hi: got %h want 0", hi); end
    endtask

    task automatic test_back_to_back;
        int cyc, nb;
        run_op(2'b00, 32'h0001_0001, 32'h0001_0001, cyc, nb);
        run_op(2'b00, 32'h0000_0010, 32'h1000_0000, cyc, nb);
        checks += 3;
        if (cyc !== 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", cyc); end
        if (hi !== 32'h0000_0001) begin errors++; $display("FAIL b2b_hi: got %h want 00000001", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL b2b_lo: got %h want 0", lo); end
    endtask

    initial begin
        test_reset;
        test_move;
        test_multu;
        test_mult;
        test_div;
        test_div_zero;
        test_ignore_while_busy;
        test_start_with_move;
        test_back_to_back;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
